// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC operation encodings and the default address width
// used by the address generator, instruction register and memory blocks.
package cpu_pkg;

    localparam int ADDR_W = 5;

    typedef enum logic [2:0] {
        PC_HOLD = 3'b000,
        PC_INC  = 3'b001,
        PC_SKIP = 3'b010,
        PC_JMP  = 3'b011,
        PC_CALL = 3'b100,
        PC_RET  = 3'b101
    } pc_op_e;

    // 110 and 111 are reserved and behave as HOLD
    function automatic logic is_hold(input logic [2:0] op);
        return (op == PC_HOLD) || (op == 3'b110) || (op == 3'b111);
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Hardware return-address stack: a DEPTH x AW LIFO that refuses a push when
// full and a pop when empty, and reports each refusal in the same cycle.
module ret_stack
    import cpu_pkg::*;
#(
    parameter int AW    = ADDR_W,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     push,
    input  logic                     pop,
    input  logic [AW-1:0]            push_data,
    output logic [AW-1:0]            top_data,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     full,
    output logic                     empty,
    output logic                     push_err,
    output logic                     pop_err
);

    localparam int IW  = $clog2(DEPTH);
    localparam int SPW = IW + 1;

    logic [AW-1:0] mem [DEPTH];
    logic [IW-1:0] wr_idx;
    logic [IW-1:0] rd_idx;

    // When sp == DEPTH the low bits wrap to 0, so rd_idx still lands on the top entry
    assign wr_idx   = sp[IW-1:0];
    assign rd_idx   = wr_idx - IW'(1);
    assign top_data = mem[rd_idx];

    assign full     = (sp == SPW'(DEPTH));
    assign empty    = (sp == '0);
    assign push_err = push & full;
    assign pop_err  = pop & empty;

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            sp <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push && !full) begin
            mem[wr_idx] <= push_data;
            sp          <= sp + SPW'(1);
        end else if (pop && !empty) begin
            sp <= sp - SPW'(1);
        end
    end

endmodule

// File: rtl/addr_gen.sv
// Address generator: program counter, operation decoder, sticky stack error
// flags and the PC / IR-operand memory address multiplexer.
module addr_gen
    import cpu_pkg::*;
#(
    parameter int          AW     = ADDR_W,
    parameter int          DEPTH  = 4,
    parameter logic [AW-1:0] RST_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic [2:0]               pc_op,
    input  logic [AW-1:0]            ir_addr,
    input  logic                     fetch,
    input  logic                     clr_err,
    output logic [AW-1:0]            addr_out,
    output logic [AW-1:0]            pc,
    output logic [$clog2(DEPTH):0]   sp,
    output logic                     stk_empty,
    output logic                     stk_full,
    output logic                     err_ovf,
    output logic                     err_unf
);

    logic          do_push;
    logic          do_pop;
    logic          push_err;
    logic          pop_err;
    logic [AW-1:0] ret_addr;
    logic [AW-1:0] top_data;

    assign ret_addr = pc + AW'(1);

    always_comb begin
        do_push = 1'b0;
        do_pop  = 1'b0;
        if (!is_hold(pc_op)) begin
            case (pc_op)
                PC_CALL: do_push = 1'b1;
                PC_RET:  do_pop  = 1'b1;
                default: ;
            endcase
        end
    end

    ret_stack #(
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_stack (
        .clk       (clk),
        .rst_      (rst_),
        .push      (do_push),
        .pop       (do_pop),
        .push_data (ret_addr),
        .top_data  (top_data),
        .sp        (sp),
        .full      (stk_full),
        .empty     (stk_empty),
        .push_err  (push_err),
        .pop_err   (pop_err)
    );

    // A refused CALL or RET leaves the PC untouched
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            pc <= RST_PC;
        end else begin
            case (pc_op)
                PC_INC:  pc <= pc + AW'(1);
                PC_SKIP: pc <= pc + AW'(2);
                PC_JMP:  pc <= ir_addr;
                PC_CALL: if (!stk_full)  pc <= ir_addr;
                PC_RET:  if (!stk_empty) pc <= top_data;
                default: ;
            endcase
        end
    end

    // An error event in the same cycle as clr_err takes precedence
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            err_ovf <= push_err | (err_ovf & ~clr_err);
            err_unf <= pop_err  | (err_unf & ~clr_err);
        end
    end

    assign addr_out = fetch ? pc : ir_addr;

endmodule

// File: tb/tb_addr_gen.sv
// Self-checking bench for addr_gen: directed test-plan sequence plus randomized
// operations, compared every cycle against a queue-style behavioural model.
`timescale 1ns/100ps
module tb_addr_gen;
    import cpu_pkg::*;

    localparam int AW    = 5;
    localparam int DEPTH = 4;
    localparam int MASK  = (1 << AW) - 1;

    logic            clk;
    logic            rst_;
    logic [2:0]      pc_op;
    logic [AW-1:0]   ir_addr;
    logic            fetch;
    logic            clr_err;

    logic [1:0][AW-1:0] addr_o;
    logic [1:0][AW-1:0] pc_o;
    logic [1:0][2:0]    sp_o;
    logic [1:0]         empty_o;
    logic [1:0]         full_o;
    logic [1:0]         ovf_o;
    logic [1:0]         unf_o;

    int  n_checks = 0;
    int  n_fail   = 0;
    bit  check_en = 0;

    // Behavioural model: one entry per DUT instance
    int  m_pc  [2];
    int  m_cnt [2];
    int  m_stk [2][DEPTH];
    bit  m_ovf [2];
    bit  m_unf [2];

    addr_gen #(.AW(AW), .DEPTH(DEPTH), .RST_PC(5'd0)) dut (
        .clk (clk), .rst_ (rst_), .pc_op (pc_op), .ir_addr (ir_addr),
        .fetch (fetch), .clr_err (clr_err), .addr_out (addr_o[0]), .pc (pc_o[0]),
        .sp (sp_o[0]), .stk_empty (empty_o[0]), .stk_full (full_o[0]),
        .err_ovf (ovf_o[0]), .err_unf (unf_o[0])
    );

    addr_gen #(.AW(AW), .DEPTH(DEPTH), .RST_PC(5'd20)) dut20 (
        .clk (clk), .rst_ (rst_), .pc_op (pc_op), .ir_addr (ir_addr),
        .fetch (fetch), .clr_err (clr_err), .addr_out (addr_o[1]), .pc (pc_o[1]),
        .sp (sp_o[1]), .stk_empty (empty_o[1]), .stk_full (full_o[1]),
        .err_ovf (ovf_o[1]), .err_unf (unf_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int rst_pc_of(input int k);
        return (k == 0) ? 0 : 20;
    endfunction

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            m_pc[k]  = rst_pc_of(k);
            m_cnt[k] = 0;
            m_ovf[k] = 0;
            m_unf[k] = 0;
            for (int j = 0; j < DEPTH; j++) m_stk[k][j] = 0;
        end
    endtask

    task automatic modelStep(input int op, input int ir, input bit clr);
        for (int k = 0; k < 2; k++) begin
            bit ovf_ev = 0;
            bit unf_ev = 0;
            case (op)
                1: m_pc[k] = (m_pc[k] + 1) & MASK;
                2: m_pc[k] = (m_pc[k] + 2) & MASK;
                3: m_pc[k] = ir;
                4: if (m_cnt[k] < DEPTH) begin
                       m_stk[k][m_cnt[k]] = (m_pc[k] + 1) & MASK;
                       m_cnt[k]++;
                       m_pc[k] = ir;
                   end else ovf_ev = 1;
                5: if (m_cnt[k] > 0) begin
                       m_cnt[k]--;
                       m_pc[k] = m_stk[k][m_cnt[k]];
                   end else unf_ev = 1;
                default: ;
            endcase
            if (clr) begin
                m_ovf[k] = 0;
                m_unf[k] = 0;
            end
            if (ovf_ev) m_ovf[k] = 1;
            if (unf_ev) m_unf[k] = 1;
        end
    endtask

    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst_);
            if (!rst_) modelReset();
            else modelStep(int'(pc_op), int'(ir_addr), clr_err);
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (check_en) begin
            for (int k = 0; k < 2; k++) begin
                checkOutput($sformatf("pc[%0d]", k), int'(pc_o[k]), m_pc[k]);
                checkOutput($sformatf("sp[%0d]", k), int'(sp_o[k]), m_cnt[k]);
                checkOutput($sformatf("empty[%0d]", k), int'(empty_o[k]), int'(m_cnt[k] == 0));
                checkOutput($sformatf("full[%0d]", k), int'(full_o[k]), int'(m_cnt[k] == DEPTH));
                checkOutput($sformatf("ovf[%0d]", k), int'(ovf_o[k]), int'(m_ovf[k]));
                checkOutput($sformatf("unf[%0d]", k), int'(unf_o[k]), int'(m_unf[k]));
                checkOutput($sformatf("addr[%0d]", k), int'(addr_o[k]),
                            fetch ? m_pc[k] : int'(ir_addr));
            end
        end
    end

    task automatic applyStimulus(input pc_op_e op, input int ir, input bit f, input bit clr);
        pc_op   = op;
        ir_addr = AW'(ir);
        fetch   = f;
        clr_err = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pins both the DUT and the model to a hand-computed PC value
    task automatic expectPc(input string name, input int exp_pc);
        checkOutput({name, " dut"}, int'(pc_o[0]), exp_pc);
        checkOutput({name, " model"}, m_pc[0], exp_pc);
    endtask

    initial begin
        rst_ = 1'b0;
        applyStimulus(PC_HOLD, 0, 1'b1, 1'b0);
        #12;
        checkOutput("reset pc", int'(pc_o[0]), 0);
        checkOutput("reset pc20", int'(pc_o[1]), 20);
        checkOutput("reset addr20", int'(addr_o[1]), 20);
        checkOutput("reset sp", int'(sp_o[0]), 0);
        checkOutput("reset empty", int'(empty_o[0]), 1);
        checkOutput("reset full", int'(full_o[0]), 0);
        check_en = 1;
        @(posedge clk);
        #1 rst_ = 1'b1;

        for (int i = 0; i < 3; i++) begin
            applyStimulus(PC_INC, 0, 1'b1, 1'b0);
            tick();
        end
        expectPc("inc3", 3);
        checkOutput("inc3 addr", int'(addr_o[0]), 3);
        applyStimulus(PC_HOLD, 22, 1'b0, 1'b0);
        #1 checkOutput("ir mux", int'(addr_o[0]), 22);

        applyStimulus(PC_JMP, 30, 1'b1, 1'b0); tick();
        applyStimulus(PC_INC, 0, 1'b1, 1'b0);  tick();
        expectPc("wrap 31", 31);
        tick();
        expectPc("wrap 0", 0);
        applyStimulus(PC_JMP, 30, 1'b1, 1'b0); tick();
        applyStimulus(PC_INC, 0, 1'b1, 1'b0);  tick();
        applyStimulus(PC_SKIP, 0, 1'b1, 1'b0); tick();
        expectPc("skip wrap", 1);

        applyStimulus(PC_JMP, 2, 1'b1, 1'b0);   tick();
        applyStimulus(PC_CALL, 16, 1'b1, 1'b0); tick();
        expectPc("call1", 16);
        checkOutput("call1 sp", int'(sp_o[0]), 1);
        applyStimulus(PC_CALL, 8, 1'b1, 1'b0);  tick();
        expectPc("call2", 8);
        checkOutput("call2 sp", int'(sp_o[0]), 2);
        applyStimulus(PC_RET, 0, 1'b1, 1'b0);   tick();
        expectPc("ret1", 17);
        tick();
        expectPc("ret2", 3);
        checkOutput("ret2 empty", int'(empty_o[0]), 1);

        applyStimulus(PC_CALL, 10, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        checkOutput("ovf full", int'(full_o[0]), 1);
        applyStimulus(PC_CALL, 7, 1'b1, 1'b0);  tick();
        expectPc("ovf pc", 10);
        checkOutput("ovf sp", int'(sp_o[0]), 4);
        checkOutput("ovf flag", int'(ovf_o[0]), 1);
        applyStimulus(PC_HOLD, 0, 1'b1, 1'b0);  tick();
        checkOutput("ovf sticky", int'(ovf_o[0]), 1);
        applyStimulus(PC_HOLD, 0, 1'b1, 1'b1);  tick();
        checkOutput("ovf cleared", int'(ovf_o[0]), 0);

        applyStimulus(PC_RET, 0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        expectPc("unwind", 4);
        tick();
        expectPc("unf pc", 4);
        checkOutput("unf flag", int'(unf_o[0]), 1);
        applyStimulus(PC_RET, 0, 1'b1, 1'b1);   tick();
        checkOutput("unf beats clr", int'(unf_o[0]), 1);

        applyStimulus(PC_CALL, 16, 1'b1, 1'b0); tick(); tick();
        checkOutput("pre-reset sp", int'(sp_o[0]), 2);
        applyStimulus(PC_CALL, 8, 1'b1, 1'b0);
        #1 rst_ = 1'b0;
        #1;
        expectPc("async rst", 0);
        checkOutput("async rst pc20", int'(pc_o[1]), 20);
        checkOutput("async rst sp", int'(sp_o[0]), 0);
        checkOutput("async rst sp20", int'(sp_o[1]), 0);
        checkOutput("async rst unf", int'(unf_o[0]), 0);
        checkOutput("async rst ovf", int'(ovf_o[0]), 0);
        checkOutput("async rst addr20", int'(addr_o[1]), 20);
        tick();
        checkOutput("held rst sp", int'(sp_o[0]), 0);
        rst_ = 1'b1;

        for (int i = 0; i < 3000; i++) begin
            int r;
            pc_op_e op;
            r  = int'($urandom_range(0, 9));
            op = (r < 3) ? PC_CALL : (r < 6) ? PC_RET : pc_op_e'($urandom_range(0, 7));
            applyStimulus(op, int'($urandom_range(0, MASK)), 1'($urandom_range(0, 1)),
                          ($urandom_range(0, 7) == 0));
            if ($urandom_range(0, 99) == 0) begin
                #1 rst_ = 1'b0;
                #2 rst_ = 1'b1;
            end
            tick();
        end

        @(negedge clk);
        #1 check_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/addr_gen.md
# addr_gen

Parametrised address generator for the CPU datapath. It is the successor to the two-input PC/IR address multiplexer: it owns the program counter and a small hardware return-address stack, and it drives the memory address from either the PC or the instruction-register operand field. It sits between the controller, which supplies `pc_op` and `fetch`, and the memory address port. Address width and stack depth are parameters.

## Interface
- `AW`, default 5: address width in bits.
- `DEPTH`, default 4: return-stack entries; power of two, at least 2.
- `RST_PC`, default 0: PC value at reset, `AW` bits.

Ports:
- `clk`, input, 1: clock; all state updates on the rising edge.
- `rst_`, input, 1: asynchronous active-low reset.
- `pc_op`, input, 3: PC operation, sampled each rising edge.
  - 000 HOLD, 001 INC, 010 SKIP, 011 JMP, 100 CALL, 101 RET.
  - 110 and 111 are treated as HOLD.
- `ir_addr`, input, AW: operand address from the IR. Used as the JMP/CALL target and as the operand memory address.
- `fetch`, input, 1: 1 drives `addr_out` from the PC; 0 drives it from `ir_addr`.
- `clr_err`, input, 1: synchronous clear of the sticky error flags.
- `addr_out`, output, AW: memory address.
- `pc`, output, AW: current PC register.
- `sp`, output, log2(DEPTH)+1: number of valid stack entries, 0..DEPTH.
- `stk_empty`, output, 1: asserted when `sp` is 0.
- `stk_full`, output, 1: asserted when `sp` equals DEPTH.
- `err_ovf`, output, 1: sticky; set by a CALL while the stack is full.
- `err_unf`, output, 1: sticky; set by a RET while the stack is empty.

## Operation
- Mux: `addr_out = fetch ? pc : ir_addr`. This is purely combinational and has no state.
- PC arithmetic is modulo 2^AW; wrap-around is silent.
  - INC: `pc <= pc+1`.
  - SKIP: `pc <= pc+2`.
  - JMP: `pc <= ir_addr`.
- CALL, stack not full:
  - push `pc+1` (mod 2^AW) into `stack[sp]`;
  - `sp <= sp+1`;
  - `pc <= ir_addr`.
- CALL, stack full: no push, PC unchanged, `sp` unchanged, `err_ovf <= 1`.
- RET, stack not empty:
  - `pc <= stack[sp-1]`;
  - `sp <= sp-1`.
- RET, stack empty: PC unchanged, `err_unf <= 1`.
- `clr_err` clears both error flags. If an error event occurs in the same cycle as `clr_err`, the event wins and the flag reads 1.
- The stack is LIFO. Entries above `sp` are don't-care and are never read.

## Timing
- Reset is asynchronous on `rst_` low:
  - `pc = RST_PC`, `sp = 0`;
  - `stk_empty = 1`, `stk_full = 0`;
  - `err_ovf = 0`, `err_unf = 0`;
  - all stack entries are cleared to 0;
  - `addr_out` follows the mux immediately (it reads `RST_PC` when `fetch` = 1).
- Reset asserted in the middle of a CALL or RET aborts the operation. No partial push or pop survives.
- Deassertion of `rst_` is synchronised externally. The first edge with `rst_` high executes `pc_op`.
- Latency:
  - `pc`, `sp`, the status flags and the error flags update one edge after `pc_op` is sampled.
  - `addr_out` tracks `fetch` and `ir_addr` with zero cycles of latency, and tracks `pc` changes in the same cycle as `pc`.
- Exactly one operation executes per cycle; there is no handshake. The controller holds `pc_op` at HOLD when it is idle.
- `stk_full` and `stk_empty` are decoded from the registered `sp`. They are therefore valid in the cycle after the push or pop.

## Structure
- Shared package `cpu_pkg`:
  - `pc_op` encodings as named constants (PC_HOLD, PC_INC, PC_SKIP, PC_JMP, PC_CALL, PC_RET);
  - the default address width, also used by the IR and memory blocks.
- Natural sub-module: `ret_stack`.
  - Parameterised LIFO of DEPTH × AW.
  - Ports: push, pop, push data, top data, `sp`, full, empty.
  - It refuses a push when full and a pop when empty, and reports the refusal.
- `addr_gen` holds the PC register, the operation decoder, the error flags and the output mux.

## Test plan
Default parameters (AW = 5, DEPTH = 4) unless stated.
- Reset, then 3 cycles of INC with `fetch` = 1 → `pc` = 3 and `addr_out` = 00011. Set `fetch` = 0 with `ir_addr` = 10110 → `addr_out` = 10110 in the same cycle.
- Wrap: JMP to 11110, then INC → `pc` = 11111; INC → 00000. From 11111, SKIP → 00001.
- CALL nesting:
  - `pc` = 2, CALL 10000 → `pc` = 16, `sp` = 1.
  - CALL 01000 → `pc` = 8, `sp` = 2.
  - RET → `pc` = 17; RET → `pc` = 3, `sp` = 0, `stk_empty` = 1.
- Overflow: 4 CALLs give `stk_full` = 1. A 5th CALL to 00111 → `pc` unchanged, `sp` = 4, `err_ovf` = 1. The flag persists until `clr_err`, then reads 0.
- Underflow: RET at `sp` = 0 → `pc` unchanged, `err_unf` = 1. RET together with `clr_err` on an empty stack → `err_unf` stays 1.
- Asynchronous reset: pull `rst_` low between clock edges during a CALL sequence with `sp` = 2 → `pc` = `RST_PC`, `sp` = 0 and both error flags 0, with no clock edge required. Repeat with `RST_PC` = 5'd20.
